// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller for BEQ/BNE in the ID stage.
// Detects EX/MEM operand hazards, forwards non-load MEM results, stalls ID
// until both operands are ready, presents registered operands to the external
// equality comparator and turns its equal flag into taken/flush/done pulses.
module branch_resolve_ctrl #(
    parameter int DATA_W   = 16,
    parameter int REG_AW   = 4,
    parameter int MAX_WAIT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              br_valid,
    input  logic              br_ne,
    input  logic [REG_AW-1:0] br_rs,
    input  logic [REG_AW-1:0] br_rt,
    input  logic [DATA_W-1:0] rf_rs_data,
    input  logic [DATA_W-1:0] rf_rt_data,
    input  logic              ex_wr_en,
    input  logic [REG_AW-1:0] ex_wr_addr,
    input  logic              mem_wr_en,
    input  logic [REG_AW-1:0] mem_wr_addr,
    input  logic              mem_is_load,
    input  logic [DATA_W-1:0] mem_wr_data,
    input  logic              cmp_equal,
    input  logic              err_clr,
    output logic [DATA_W-1:0] cmp_a,
    output logic [DATA_W-1:0] cmp_b,
    output logic              stall_id,
    output logic              flush_if,
    output logic              br_taken,
    output logic              br_done,
    output logic              timeout_err
);

    localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HAZ_WAIT = 2'd1,
        EVAL     = 2'd2
    } state_t;

    state_t            state_r;
    logic [REG_AW-1:0] rs_r;
    logic [REG_AW-1:0] rt_r;
    logic              ne_r;
    logic [CNT_W-1:0]  wait_cnt_r;

    logic [REG_AW-1:0] src_rs_s;
    logic [REG_AW-1:0] src_rt_s;
    logic              haz_any_s;
    logic [DATA_W-1:0] opnd_a_s;
    logic [DATA_W-1:0] opnd_b_s;
    logic              taken_s;
    logic              wait_last_s;

    // A source is not ready while an older instruction will write it but
    // cannot forward yet (anything in EX, or a load in MEM); r0 never waits.
    function automatic logic src_hazard(
        input logic [REG_AW-1:0] src,
        input logic              ex_en,
        input logic [REG_AW-1:0] ex_addr,
        input logic              mem_en,
        input logic              mem_ld,
        input logic [REG_AW-1:0] mem_addr
    );
        logic hit;
        hit = 1'b0;
        if (src != {REG_AW{1'b0}}) begin
            hit = (ex_en && (ex_addr == src)) ||
                  (mem_en && mem_ld && (mem_addr == src));
        end else begin
            hit = 1'b0;
        end
        return hit;
    endfunction

    // Operand value: r0 reads as zero, a non-load MEM result wins over the
    // register file, otherwise the register-file read data is used.
    function automatic logic [DATA_W-1:0] src_operand(
        input logic [REG_AW-1:0] src,
        input logic [DATA_W-1:0] rf_data,
        input logic              mem_en,
        input logic              mem_ld,
        input logic [REG_AW-1:0] mem_addr,
        input logic [DATA_W-1:0] mem_data
    );
        logic [DATA_W-1:0] val;
        val = rf_data;
        if (src == {REG_AW{1'b0}}) begin
            val = {DATA_W{1'b0}};
        end else if (mem_en && !mem_ld && (mem_addr == src)) begin
            val = mem_data;
        end else begin
            val = rf_data;
        end
        return val;
    endfunction

    // Hazard and operand evaluation: IDLE looks at the incoming branch,
    // HAZ_WAIT re-checks the registers latched at acceptance.
    always_comb begin
        src_rs_s = rs_r;
        src_rt_s = rt_r;
        if (state_r == IDLE) begin
            src_rs_s = br_rs;
            src_rt_s = br_rt;
        end else begin
            src_rs_s = rs_r;
            src_rt_s = rt_r;
        end
        haz_any_s = src_hazard(src_rs_s, ex_wr_en, ex_wr_addr, mem_wr_en, mem_is_load, mem_wr_addr) ||
                    src_hazard(src_rt_s, ex_wr_en, ex_wr_addr, mem_wr_en, mem_is_load, mem_wr_addr);
        opnd_a_s    = src_operand(src_rs_s, rf_rs_data, mem_wr_en, mem_is_load, mem_wr_addr, mem_wr_data);
        opnd_b_s    = src_operand(src_rt_s, rf_rt_data, mem_wr_en, mem_is_load, mem_wr_addr, mem_wr_data);
        taken_s     = cmp_equal ^ ne_r;
        wait_last_s = (wait_cnt_r == CNT_LAST);
    end

    // ID stall: held from acceptance until the operands are loaded.
    always_comb begin
        stall_id = 1'b0;
        case (state_r)
            IDLE:     stall_id = br_valid;
            HAZ_WAIT: stall_id = 1'b1;
            EVAL:     stall_id = 1'b0;
            default:  stall_id = 1'b0;
        endcase
    end

    // Resolution FSM with registered operands, pulses and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            rs_r        <= {REG_AW{1'b0}};
            rt_r        <= {REG_AW{1'b0}};
            ne_r        <= 1'b0;
            wait_cnt_r  <= {CNT_W{1'b0}};
            cmp_a       <= {DATA_W{1'b0}};
            cmp_b       <= {DATA_W{1'b0}};
            flush_if    <= 1'b0;
            br_taken    <= 1'b0;
            br_done     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            br_done  <= 1'b0;
            br_taken <= 1'b0;
            flush_if <= 1'b0;
            // A timeout set below overrides this clear in the same cycle.
            if (err_clr) begin
                timeout_err <= 1'b0;
            end else begin
                timeout_err <= timeout_err;
            end
            case (state_r)
                IDLE: begin
                    if (br_valid) begin
                        rs_r <= br_rs;
                        rt_r <= br_rt;
                        ne_r <= br_ne;
                        if (!haz_any_s) begin
                            cmp_a   <= opnd_a_s;
                            cmp_b   <= opnd_b_s;
                            state_r <= EVAL;
                        end else begin
                            wait_cnt_r <= {CNT_W{1'b0}};
                            state_r    <= HAZ_WAIT;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                HAZ_WAIT: begin
                    if (!br_valid) begin
                        state_r <= IDLE;
                    end else if (!haz_any_s) begin
                        cmp_a   <= opnd_a_s;
                        cmp_b   <= opnd_b_s;
                        state_r <= EVAL;
                    end else if (wait_last_s) begin
                        timeout_err <= 1'b1;
                        br_done     <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                EVAL: begin
                    br_taken <= taken_s;
                    flush_if <= taken_s;
                    br_done  <= 1'b1;
                    state_r  <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl. Each branch is given a
// per-cycle pipeline environment; the reference model finds the first cycle in
// the allowed window where neither source is blocked and derives stall, pulse,
// operand and flag expectations from that.
module tb_branch_resolve_ctrl;

    localparam int DATA_W   = 16;
    localparam int REG_AW   = 4;
    localparam int MAX_WAIT = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              br_valid = 1'b0;
    logic              br_ne = 1'b0;
    logic [REG_AW-1:0] br_rs = '0;
    logic [REG_AW-1:0] br_rt = '0;
    logic [DATA_W-1:0] rf_rs_data = '0;
    logic [DATA_W-1:0] rf_rt_data = '0;
    logic              ex_wr_en = 1'b0;
    logic [REG_AW-1:0] ex_wr_addr = '0;
    logic              mem_wr_en = 1'b0;
    logic [REG_AW-1:0] mem_wr_addr = '0;
    logic              mem_is_load = 1'b0;
    logic [DATA_W-1:0] mem_wr_data = '0;
    logic              cmp_equal;
    logic              err_clr = 1'b0;
    logic [DATA_W-1:0] cmp_a;
    logic [DATA_W-1:0] cmp_b;
    logic              stall_id;
    logic              flush_if;
    logic              br_taken;
    logic              br_done;
    logic              timeout_err;

    branch_resolve_ctrl #(.DATA_W(DATA_W), .REG_AW(REG_AW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ne(br_ne),
        .br_rs(br_rs), .br_rt(br_rt), .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data),
        .ex_wr_en(ex_wr_en), .ex_wr_addr(ex_wr_addr), .mem_wr_en(mem_wr_en),
        .mem_wr_addr(mem_wr_addr), .mem_is_load(mem_is_load), .mem_wr_data(mem_wr_data),
        .cmp_equal(cmp_equal), .err_clr(err_clr), .cmp_a(cmp_a), .cmp_b(cmp_b),
        .stall_id(stall_id), .flush_if(flush_if), .br_taken(br_taken),
        .br_done(br_done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // The external comparator.
    assign cmp_equal = (cmp_a == cmp_b);

    int nvec = 0;
    int nerr = 0;

    // Model state.
    logic [DATA_W-1:0] m_a = '0;
    logic [DATA_W-1:0] m_b = '0;
    logic              m_terr = 1'b0;

    // Per-cycle environment for one branch: index = cycles since acceptance.
    logic              e_ex_en  [0:3];
    logic [REG_AW-1:0] e_ex_ad  [0:3];
    logic              e_mem_en [0:3];
    logic [REG_AW-1:0] e_mem_ad [0:3];
    logic              e_mem_ld [0:3];
    logic [DATA_W-1:0] e_mem_dt [0:3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_env();
        for (int k = 0; k < 4; k++) begin
            e_ex_en[k] = 1'b0; e_ex_ad[k] = '0; e_mem_en[k] = 1'b0;
            e_mem_ad[k] = '0; e_mem_ld[k] = 1'b0; e_mem_dt[k] = '0;
        end
    endtask

    task automatic set_env(input int k, input logic xen, input logic [3:0] xad,
                           input logic men, input logic [3:0] mad, input logic mld,
                           input logic [15:0] mdt);
        e_ex_en[k] = xen; e_ex_ad[k] = xad; e_mem_en[k] = men;
        e_mem_ad[k] = mad; e_mem_ld[k] = mld; e_mem_dt[k] = mdt;
    endtask

    task automatic drive_env(input int k);
        if (k <= 3) begin
            ex_wr_en = e_ex_en[k]; ex_wr_addr = e_ex_ad[k]; mem_wr_en = e_mem_en[k];
            mem_wr_addr = e_mem_ad[k]; mem_is_load = e_mem_ld[k]; mem_wr_data = e_mem_dt[k];
        end else begin
            ex_wr_en = 1'b0; ex_wr_addr = '0; mem_wr_en = 1'b0;
            mem_wr_addr = '0; mem_is_load = 1'b0; mem_wr_data = '0;
        end
    endtask

    function automatic bit blocked(input int k, input logic [3:0] s);
        if (s == 4'd0) return 1'b0;
        return (e_ex_en[k] && e_ex_ad[k] == s) || (e_mem_en[k] && e_mem_ld[k] && e_mem_ad[k] == s);
    endfunction

    function automatic logic [15:0] value_of(input int k, input logic [3:0] s, input logic [15:0] rf);
        if (s == 4'd0) return 16'h0000;
        if (e_mem_en[k] && !e_mem_ld[k] && e_mem_ad[k] == s) return e_mem_dt[k];
        return rf;
    endfunction

    // Check all registered outputs against the model after an edge.
    task automatic check_regs(input string tag, input logic done, input logic tk);
        chk({tag, ".br_done"}, {31'd0, br_done}, {31'd0, done});
        chk({tag, ".br_taken"}, {31'd0, br_taken}, {31'd0, tk});
        chk({tag, ".flush_if"}, {31'd0, flush_if}, {31'd0, tk});
        chk({tag, ".timeout_err"}, {31'd0, timeout_err}, {31'd0, m_terr});
        chk({tag, ".cmp_a"}, {16'd0, cmp_a}, {16'd0, m_a});
        chk({tag, ".cmp_b"}, {16'd0, cmp_b}, {16'd0, m_b});
    endtask

    // One branch; kind 0 = resolves, 1 = times out, 2 = aborted by br_valid low.
    task automatic run_branch(input string tag, input logic ne, input logic [3:0] rs,
                              input logic [3:0] rt, input logic [15:0] rfa,
                              input logic [15:0] rfb, input int abort_at, input logic clr_last);
        int first_clear;
        int kind;
        int last;
        logic [15:0] ea;
        logic [15:0] eb;
        logic tk;
        first_clear = -1;
        for (int k = 0; k <= MAX_WAIT; k++)
            if (first_clear < 0 && !(blocked(k, rs) || blocked(k, rt))) first_clear = k;
        if (abort_at >= 1 && abort_at <= MAX_WAIT && (first_clear < 0 || abort_at <= first_clear)) begin
            kind = 2; last = abort_at;
        end else if (first_clear >= 0) begin
            kind = 0; last = first_clear + 1;
        end else begin
            kind = 1; last = MAX_WAIT;
        end
        ea = 16'h0; eb = 16'h0; tk = 1'b0;
        if (kind == 0) begin
            ea = value_of(first_clear, rs, rfa);
            eb = value_of(first_clear, rt, rfb);
            tk = (ea == eb) ^ ne;
        end
        for (int k = 0; k <= last; k++) begin
            br_valid = !(kind == 2 && k == last);
            br_ne = ne; br_rs = rs; br_rt = rt;
            rf_rs_data = rfa; rf_rt_data = rfb;
            drive_env(k);
            err_clr = clr_last && (k == last);
            #1;
            chk({tag, ".stall_id"}, {31'd0, stall_id}, {31'd0, !(kind == 0 && k == last)});
            @(posedge clk); #1;
            if (kind == 0 && k == first_clear) begin m_a = ea; m_b = eb; end
            if (err_clr) m_terr = 1'b0;
            if (kind == 1 && k == last) m_terr = 1'b1;
            check_regs(tag, (kind != 2) && (k == last), (kind == 0) && (k == last) && tk);
        end
        br_valid = 1'b0;
        err_clr = 1'b0;
        drive_env(4);
    endtask

    task automatic idle_cycle(input logic clr);
        br_valid = 1'b0;
        err_clr = clr;
        ex_wr_en = 1'b1; ex_wr_addr = 4'($urandom_range(0, 15));
        #1;
        chk("idle.stall_id", {31'd0, stall_id}, 32'd0);
        @(posedge clk); #1;
        if (clr) m_terr = 1'b0;
        check_regs("idle", 1'b0, 1'b0);
        err_clr = 1'b0;
        drive_env(4);
    endtask

    initial begin
        logic [15:0] va;
        logic [15:0] vb;
        int ab;
        clear_env();
        // Reset state.
        #12;
        chk("reset.stall_id", {31'd0, stall_id}, 32'd0);
        check_regs("reset", 1'b0, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // BEQ equal, no hazard.
        run_branch("beq_eq", 1'b0, 4'd1, 4'd2, 16'h1234, 16'h1234, -1, 1'b0);
        idle_cycle(1'b0);
        // BNE unequal / equal.
        run_branch("bne_ne", 1'b1, 4'd3, 4'd4, 16'h00FF, 16'h00FE, -1, 1'b0);
        run_branch("bne_eq", 1'b1, 4'd3, 4'd4, 16'h5555, 16'h5555, -1, 1'b0);
        // EX hazard then MEM forwarding.
        clear_env();
        set_env(0, 1'b1, 4'd5, 1'b0, 4'd0, 1'b0, 16'h0000);
        set_env(1, 1'b0, 4'd0, 1'b1, 4'd5, 1'b0, 16'hBEEF);
        run_branch("mem_fwd", 1'b0, 4'd5, 4'd6, 16'h1111, 16'hBEEF, -1, 1'b0);
        // Load in EX, then in MEM, then resolved from rf.
        clear_env();
        set_env(0, 1'b1, 4'd6, 1'b0, 4'd0, 1'b0, 16'h0000);
        set_env(1, 1'b0, 4'd0, 1'b1, 4'd6, 1'b1, 16'h7777);
        run_branch("load_wait", 1'b0, 4'd6, 4'd7, 16'h0042, 16'h0042, -1, 1'b0);
        // r0 never hazards even when EX writes address 0.
        clear_env();
        set_env(0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 16'h0000);
        run_branch("r0_zero", 1'b0, 4'd0, 4'd7, 16'hABCD, 16'h0000, -1, 1'b0);
        // Persistent hazard: timeout, with err_clr in the same cycle (set wins).
        clear_env();
        for (int k = 0; k < 4; k++) set_env(k, 1'b1, 4'd8, 1'b0, 4'd0, 1'b0, 16'h0000);
        run_branch("timeout", 1'b0, 4'd8, 4'd1, 16'h0001, 16'h0001, -1, 1'b1);
        idle_cycle(1'b0);
        // Asynchronous reset while waiting.
        br_valid = 1'b1; br_rs = 4'd8; br_rt = 4'd1; drive_env(0);
        @(posedge clk); #1;
        drive_env(1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        br_valid = 1'b0;
        #1;
        m_a = '0; m_b = '0; m_terr = 1'b0;
        chk("rst_mid.stall_id", {31'd0, stall_id}, 32'd0);
        check_regs("rst_mid", 1'b0, 1'b0);
        #2 rst_n = 1'b1;
        drive_env(4);
        @(posedge clk); #1;
        check_regs("rst_after", 1'b0, 1'b0);
        // Abort by br_valid low while waiting.
        run_branch("abort", 1'b0, 4'd8, 4'd1, 16'h0001, 16'h0001, 2, 1'b0);
        idle_cycle(1'b0);
        // Timeout then explicit clear.
        run_branch("timeout2", 1'b1, 4'd8, 4'd2, 16'h0003, 16'h0004, -1, 1'b0);
        idle_cycle(1'b1);

        // Randomized branches.
        for (int n = 0; n < 150; n++) begin
            for (int k = 0; k < 4; k++)
                set_env(k, ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 7)),
                        ($urandom_range(0, 1) == 0), 4'($urandom_range(0, 7)),
                        ($urandom_range(0, 2) == 0), 16'($urandom));
            va = 16'($urandom);
            vb = ($urandom_range(0, 2) == 0) ? va : 16'($urandom);
            ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : -1;
            run_branch("rand", 1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)),
                       4'($urandom_range(0, 7)), va, vb, ab, ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 2) == 0) idle_cycle(($urandom_range(0, 1) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
